// File: rtl/uart_program_loader.sv
// UART 8N1 program loader: receives a length-prefixed image, packs little-endian
// 32-bit words into RAM and holds the CPU in reset until the image is complete.
module uart_program_loader #(
   parameter int CLKS_PER_BIT = 868,
   parameter int ADDR_WIDTH   = 14
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rxd,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic                  cpu_reset,
   output logic                  busy,
   output logic                  frame_err
);

   localparam int            CW   = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
   typedef enum logic [1:0] {S_LEN0, S_LEN1, S_DATA, S_DONE} ld_state_t;

   rx_state_t       r_rx_state, w_rx_next;
   ld_state_t       r_ld_state, w_ld_next;
   logic            r_rx_meta, r_rx_sync;
   logic [CW-1:0]   r_clk_cnt;
   logic [2:0]      r_bit_idx;
   logic [7:0]      r_shift;
   logic            r_rx_valid;
   logic [7:0]      r_rx_byte;
   logic            r_frame_err;
   logic            w_tick;

   logic [15:0]           r_len;
   logic [15:0]           r_word_cnt;
   logic [1:0]            r_byte_cnt;
   logic [23:0]           r_word;
   logic                  r_mem_we;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [31:0]           r_mem_wdata;
   logic                  r_cpu_reset;
   logic                  w_word_done;

   // NOTE: the synchronizer resets to the idle (high) level so reset release
   // never looks like a start bit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
      end else begin
         r_rx_meta <= rxd;
         r_rx_sync <= r_rx_meta;
      end
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      w_rx_next = r_rx_state;
      w_tick    = 1'b0;
      case (r_rx_state)
         RX_IDLE:  if (!r_rx_sync) w_rx_next = RX_START;
         RX_START: if (r_clk_cnt == HALF) begin
                      w_tick    = 1'b1;
                      w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA;
                   end
         RX_DATA:  if (r_clk_cnt == FULL) begin
                      w_tick = 1'b1;
                      if (r_bit_idx == 3'd7) w_rx_next = RX_STOP;
                   end
         RX_STOP:  if (r_clk_cnt == FULL) begin
                      w_tick    = 1'b1;
                      w_rx_next = r_rx_sync ? RX_IDLE : RX_WAIT;
                   end
         RX_WAIT:  if (r_rx_sync) w_rx_next = RX_IDLE;
         default:  w_rx_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rx_state  <= RX_IDLE;
         r_clk_cnt   <= '0;
         r_bit_idx   <= '0;
         r_shift     <= '0;
         r_rx_valid  <= 1'b0;
         r_rx_byte   <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_rx_state <= w_rx_next;
         r_rx_valid <= 1'b0;
         if (w_tick || r_rx_state == RX_IDLE || r_rx_state == RX_WAIT) r_clk_cnt <= '0;
         else                                                          r_clk_cnt <= r_clk_cnt + 1'b1;
         if (w_tick && r_rx_state == RX_DATA) begin
            r_shift   <= {r_rx_sync, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
         end
         if (w_tick && r_rx_state == RX_STOP) begin
            if (r_rx_sync) begin
               r_rx_valid <= 1'b1;
               r_rx_byte  <= r_shift;
            end else begin
               r_frame_err <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      w_ld_next   = r_ld_state;
      w_word_done = 1'b0;
      case (r_ld_state)
         S_LEN0: if (r_rx_valid) w_ld_next = S_LEN1;
         S_LEN1: if (r_rx_valid) w_ld_next = ({r_rx_byte, r_len[7:0]} == 16'd0) ? S_DONE : S_DATA;
         S_DATA: if (r_rx_valid && r_byte_cnt == 2'd3) begin
                    w_word_done = 1'b1;
                    if (r_word_cnt + 16'd1 == r_len) w_ld_next = S_DONE;
                 end
         default: w_ld_next = S_DONE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ld_state  <= S_LEN0;
         r_len       <= '0;
         r_word_cnt  <= '0;
         r_byte_cnt  <= '0;
         r_word      <= '0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_cpu_reset <= 1'b0;
      end else begin
         r_ld_state  <= w_ld_next;
         r_mem_we    <= w_word_done;
         r_cpu_reset <= (r_ld_state == S_DONE);
         if (r_rx_valid) begin
            case (r_ld_state)
               S_LEN0: r_len[7:0] <= r_rx_byte;
               S_LEN1: begin
                  r_len[15:8] <= r_rx_byte;
                  r_word_cnt  <= '0;
                  r_byte_cnt  <= '0;
               end
               S_DATA: begin
                  if (w_word_done) begin
                     r_mem_wdata <= {r_rx_byte, r_word};
                     r_mem_addr  <= r_word_cnt[ADDR_WIDTH-1:0];
                     r_word_cnt  <= r_word_cnt + 16'd1;
                     r_byte_cnt  <= '0;
                  end else begin
                     case (r_byte_cnt)
                        2'd0:    r_word[7:0]   <= r_rx_byte;
                        2'd1:    r_word[15:8]  <= r_rx_byte;
                        default: r_word[23:16] <= r_rx_byte;
                     endcase
                     r_byte_cnt <= r_byte_cnt + 2'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign cpu_reset = r_cpu_reset;
   assign busy      = (r_ld_state != S_DONE);
   assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_program_loader.sv
// Randomized self-checking bench for uart_program_loader against a byte-stream
// reference model of the image format.
module tb_uart_program_loader;

   localparam int CPB = 4;
   localparam int AW  = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          rxd;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          cpu_reset;
   logic          busy;
   logic          frame_err;

   always #5 clk = ~clk;

   uart_program_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
      .clk       (clk),
      .reset     (reset),
      .rxd       (rxd),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_reset (cpu_reset),
      .busy      (busy),
      .frame_err (frame_err)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Write monitor, sampled on the falling edge.
   int            cyc = 0;
   logic [AW-1:0] got_addr[$];
   logic [31:0]   got_data[$];
   int            last_we_cyc = -1;
   int            rise_cyc = -1;
   logic          prev_we = 1'b0;
   logic          prev_cpu = 1'b0;
   logic          dbl_we = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (mem_we === 1'b1) begin
         got_addr.push_back(mem_addr);
         got_data.push_back(mem_wdata);
         last_we_cyc = cyc;
         if (prev_we) dbl_we = 1'b1;
      end
      if (cpu_reset === 1'b1 && !prev_cpu && rise_cyc < 0) rise_cyc = cyc;
      prev_we  = (mem_we === 1'b1);
      prev_cpu = (cpu_reset === 1'b1);
   end

   // Transmitted stream and reference model outputs.
   logic [7:0]    tx_bytes[$];
   logic          tx_bad[$];
   logic [AW-1:0] exp_addr[$];
   logic [31:0]   exp_data[$];
   logic          exp_done;
   logic          exp_ferr;

   task automatic run_model();
      logic [7:0] ok[$];
      int len, avail, nw;
      exp_addr.delete();
      exp_data.delete();
      exp_ferr = 1'b0;
      foreach (tx_bytes[i]) begin
         if (tx_bad[i]) exp_ferr = 1'b1;
         else           ok.push_back(tx_bytes[i]);
      end
      exp_done = 1'b0;
      if (ok.size() >= 2) begin
         len   = ok[0] + 256 * ok[1];
         avail = (ok.size() - 2) / 4;
         nw    = (avail < len) ? avail : len;
         exp_done = (avail >= len);
         for (int w = 0; w < nw; w++) begin
            exp_addr.push_back(AW'(w % (1 << AW)));
            exp_data.push_back({ok[2+4*w+3], ok[2+4*w+2], ok[2+4*w+1], ok[2+4*w]});
         end
      end
   endtask

   task automatic bit_time(input logic v);
      rxd = v;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic bad);
      tx_bytes.push_back(b);
      tx_bad.push_back(bad);
      bit_time(1'b0);
      for (int i = 0; i < 8; i++) bit_time(b[i]);
      bit_time(!bad);
      rxd = 1'b1;
      repeat (2 * CPB) @(negedge clk);
   endtask

   task automatic send_list(input logic [7:0] bytes[$]);
      foreach (bytes[i]) send_byte(bytes[i], 1'b0);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check({tag, " rst mem_we"},    mem_we,    0);
      check({tag, " rst mem_addr"},  mem_addr,  0);
      check({tag, " rst mem_wdata"}, mem_wdata, 0);
      check({tag, " rst cpu_reset"}, cpu_reset, 0);
      check({tag, " rst busy"},      busy,      1);
      check({tag, " rst frame_err"}, frame_err, 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      tx_bytes.delete();
      tx_bad.delete();
      got_addr.delete();
      got_data.delete();
      last_we_cyc = -1;
      rise_cyc    = -1;
      dbl_we      = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic finish_scenario(input string tag);
      int n;
      repeat (20) @(negedge clk);
      run_model();
      check({tag, " write count"}, got_addr.size(), exp_addr.size());
      n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s addr[%0d]", tag, i), got_addr[i], exp_addr[i]);
         check($sformatf("%s data[%0d]", tag, i), got_data[i], exp_data[i]);
      end
      check({tag, " cpu_reset"}, cpu_reset, exp_done);
      check({tag, " busy"},      busy,      !exp_done);
      check({tag, " frame_err"}, frame_err, exp_ferr);
      check({tag, " no back-to-back we"}, dbl_we, 0);
      if (exp_done && exp_addr.size() > 0)
         check({tag, " cpu_reset latency"}, rise_cyc, last_we_cyc + 1);
      else if (exp_done)
         check({tag, " cpu_reset rose"}, rise_cyc >= 0, 1);
   endtask

   initial begin
      logic [7:0] img[$];
      reset = 1'b1;
      rxd   = 1'b1;

      do_reset("init");
      img = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      send_list(img);
      finish_scenario("two words");
      check("two words data0", got_data.size() > 0 ? got_data[0] : 32'h0, 32'h12345678);

      do_reset("after two words");
      img = '{8'h00, 8'h00};
      send_list(img);
      finish_scenario("len0");
      send_byte(8'h55, 1'b0);
      finish_scenario("len0 extra");

      do_reset("after len0");
      @(negedge clk) rxd = 1'b0;
      @(negedge clk) rxd = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      img = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      send_list(img);
      finish_scenario("glitch");
      check("glitch data", got_data.size() > 0 ? got_data[0] : 32'h0, 32'hDDCCBBAA);

      do_reset("after glitch");
      img = '{8'h01, 8'h00, 8'hAA};
      send_list(img);
      send_byte(8'hBB, 1'b1);
      img = '{8'hCC, 8'hDD};
      send_list(img);
      finish_scenario("ferr partial");
      send_byte(8'hEE, 1'b0);
      finish_scenario("ferr complete");
      check("ferr data", got_data.size() > 0 ? got_data[0] : 32'h0, 32'hEEDDCCAA);

      do_reset("after ferr");
      send_byte(8'h11, 1'b0);
      send_byte(8'h00, 1'b0);
      for (int i = 0; i < 68; i++) send_byte(8'(i), 1'b0);
      finish_scenario("wrap17");
      check("wrap17 last addr", got_addr.size() == 17 ? got_addr[16] : AW'(4'hF), 0);

      do_reset("after wrap17");
      img = '{8'h01, 8'h00, 8'h04, 8'h03};
      send_list(img);
      do_reset("mid image");
      img = '{8'h01, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01};
      send_list(img);
      finish_scenario("restart");
      check("restart data", got_data.size() > 0 ? got_data[0] : 32'h0, 32'h01020304);

      for (int r = 0; r < 5; r++) begin
         int len, nb;
         do_reset($sformatf("rnd%0d pre", r));
         len = $urandom_range(0, 5);
         nb  = 2 + 4 * len + $urandom_range(0, 2);
         for (int i = 0; i < nb; i++) begin
            logic [7:0] b;
            logic bad;
            b   = (i == 0) ? 8'(len) : (i == 1) ? 8'h00 : 8'($urandom);
            bad = (i >= 2) && ($urandom_range(0, 15) == 0);
            send_byte(b, bad);
         end
         finish_scenario($sformatf("rnd%0d", r));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
